// File: rtl/charlcd_bus_sequencer_if.sv
// Request handshake from the APB register bank plus the LCD pin bundle.
// master = requester side, slave = sequencer side.
interface charlcd_bus_sequencer_if;
  logic       req_valid;
  logic       req_rs;
  logic [7:0] req_data;
  logic       req_ready;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;
  logic [7:0] LCD_DATA;

  modport master (
    output req_valid, req_rs, req_data,
    input  req_ready, LCD_RS, LCD_RW, LCD_EN, LCD_DATA
  );

  modport slave (
    input  req_valid, req_rs, req_data,
    output req_ready, LCD_RS, LCD_RW, LCD_EN, LCD_DATA
  );
endinterface

// File: rtl/charlcd_bus_sequencer.sv
// Write-only HD44780-style LCD bus sequencer: power-up delay, 7-entry init ROM,
// then handshake-driven command/data writes with programmable bus timing.
module charlcd_bus_sequencer #(
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_SETUP   = 2,
  parameter int unsigned T_PULSE   = 12,
  parameter int unsigned T_HOLD    = 2,
  parameter int unsigned T_EXEC    = 2000,
  parameter int unsigned T_LONG    = 250000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  charlcd_bus_sequencer_if.slave  bus,
  output logic                    init_done,
  output logic                    busy
);

  typedef enum logic [2:0] {
    StPwrup,
    StSetup,
    StPulse,
    StHold,
    StExec,
    StIdle
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               rs_q, rs_d;
  logic [7:0]         data_q, data_d;
  logic               long_q, long_d;
  logic [2:0]         idx_q, idx_d;
  logic               init_done_q, init_done_d;
  logic               ready;
  logic               timer_zero;
  logic               exec_long;

  // Init ROM contents; all entries are commands (RS=0).
  function automatic logic [7:0] rom_byte(input logic [2:0] idx);
    logic [7:0] b;
    unique case (idx)
      3'd0, 3'd1, 3'd2: b = 8'h38;
      3'd3:             b = 8'h08;
      3'd4:             b = 8'h01;
      3'd5:             b = 8'h06;
      3'd6:             b = 8'h0C;
      default:          b = 8'h00;
    endcase
    return b;
  endfunction

  // The three function-set steps need the long execute wait even though
  // their opcode alone would not select it.
  function automatic logic rom_long(input logic [2:0] idx);
    return idx <= 3'd2;
  endfunction

  assign ready      = (state_q == StIdle) && init_done_q;
  assign timer_zero = (timer_q == '0);
  assign exec_long  = long_q || (!rs_q && (data_q[7:2] == 6'd0));

  // Next-state, timer and latched-byte logic.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    rs_d        = rs_q;
    data_d      = data_q;
    long_d      = long_q;
    idx_d       = idx_q;
    init_done_d = init_done_q;
    unique case (state_q)
      // Power-up counts up from the reset value of 0 so no load is needed.
      StPwrup: begin
        if (timer_q == CNT_W'(T_POWERUP - 1)) begin
          state_d = StSetup;
          timer_d = CNT_W'(T_SETUP - 1);
          rs_d    = 1'b0;
          data_d  = rom_byte(3'd0);
          long_d  = rom_long(3'd0);
          idx_d   = 3'd0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StSetup: begin
        if (timer_zero) begin
          state_d = StPulse;
          timer_d = CNT_W'(T_PULSE - 1);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StPulse: begin
        if (timer_zero) begin
          state_d = StHold;
          timer_d = CNT_W'(T_HOLD - 1);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StHold: begin
        if (timer_zero) begin
          state_d = StExec;
          timer_d = exec_long ? CNT_W'(T_LONG - 1) : CNT_W'(T_EXEC - 1);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      StExec: begin
        if (!timer_zero) begin
          timer_d = timer_q - 1'b1;
        end else if (!init_done_q && (idx_q < 3'd6)) begin
          state_d = StSetup;
          timer_d = CNT_W'(T_SETUP - 1);
          idx_d   = idx_q + 3'd1;
          rs_d    = 1'b0;
          data_d  = rom_byte(idx_q + 3'd1);
          long_d  = rom_long(idx_q + 3'd1);
        end else begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end
      StIdle: begin
        if (bus.req_valid && ready) begin
          state_d = StSetup;
          timer_d = CNT_W'(T_SETUP - 1);
          rs_d    = bus.req_rs;
          data_d  = bus.req_data;
          long_d  = 1'b0;
        end
      end
      default: begin
        state_d = StPwrup;
        timer_d = '0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q     <= StPwrup;
      timer_q     <= '0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      long_q      <= 1'b0;
      idx_q       <= 3'd0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      long_q      <= long_d;
      idx_q       <= idx_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.LCD_RS    = rs_q;
  assign bus.LCD_RW    = 1'b0;
  assign bus.LCD_EN    = (state_q == StPulse);
  assign bus.LCD_DATA  = data_q;
  assign init_done     = init_done_q;
  assign busy          = !ready;

endmodule

// File: tb/tb_charlcd_bus_sequencer.sv
// Bench for charlcd_bus_sequencer: cycle-accurate reference model built from
// per-byte time offsets, directed vectors, corner sequences and random traffic.
module tb_charlcd_bus_sequencer;
  localparam int TP  = 50;
  localparam int TS  = 1;
  localparam int TPU = 3;
  localparam int TH  = 1;
  localparam int TE  = 5;
  localparam int TL  = 20;
  localparam int SHORT_LAT = TS + TPU + TH + TE;
  localparam int LONG_LAT  = TS + TPU + TH + TL;

  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  logic init_done, busy;

  charlcd_bus_sequencer_if bus ();

  charlcd_bus_sequencer #(
    .T_POWERUP(TP), .T_SETUP(TS), .T_PULSE(TPU), .T_HOLD(TH),
    .T_EXEC(TE), .T_LONG(TL), .CNT_W(20)
  ) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus),
    .init_done(init_done),
    .busy(busy)
  );

  always #5 PCLK = ~PCLK;

  int n_chk = 0;
  int n_pass = 0;

  logic [7:0] rom [7] = '{8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

  // Reference model: one byte in flight, described by its start cycle offset.
  bit         m_live = 0;
  bit         m_run, m_init;
  int         m_pwr, m_off, m_len, m_idx;
  logic       m_rs;
  logic [7:0] m_data;
  logic [8:0] exp_q [$];

  // Observation of the DUT's pins.
  int         cyc, rises, en_hi, low_run, last_gap, rise_cyc, first_rise;
  logic       en_prev;
  logic [8:0] cap [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
  endtask

  task automatic model_start(input logic rs, input logic [7:0] d, input bit lng);
    m_run  = 1;
    m_off  = 0;
    m_rs   = rs;
    m_data = d;
    m_len  = TS + TPU + TH + ((lng || (!rs && d[7:2] == 6'd0)) ? TL : TE);
    exp_q.push_back({rs, d});
  endtask

  // Apply the rules to what happens at the coming clock edge.
  task automatic model_edge();
    if (!PRESETn) begin
      m_live = 1; m_pwr = 0; m_run = 0; m_init = 0; m_rs = 0; m_data = 8'h00; m_idx = 0;
      exp_q.delete();
      cyc = 0;
    end else if (m_live) begin
      cyc++;
      if (m_pwr >= 0) begin
        if (m_pwr == TP - 1) begin
          m_pwr = -1;
          model_start(1'b0, rom[0], 1);
        end else m_pwr++;
      end else if (m_run) begin
        if (m_off == m_len - 1) begin
          m_run = 0;
          if (!m_init) begin
            if (m_idx < 6) begin
              m_idx++;
              model_start(1'b0, rom[m_idx], m_idx < 3);
            end else m_init = 1;
          end
        end else m_off++;
      end else if (m_init && bus.req_valid) begin
        model_start(bus.req_rs, bus.req_data, 0);
      end
    end
  endtask

  task automatic step();
    logic       exp_en, exp_rdy, has;
    logic [8:0] exp_b;
    model_edge();
    @(posedge PCLK);
    #1;
    exp_en  = m_run && (m_off >= TS) && (m_off < TS + TPU);
    exp_rdy = m_init && !m_run && (m_pwr < 0);
    check("pins", {18'd0, bus.LCD_EN, bus.LCD_RS, bus.LCD_RW, bus.LCD_DATA,
                   bus.req_ready, busy, init_done},
                  {18'd0, exp_en, m_rs, 1'b0, m_data, exp_rdy, !exp_rdy, m_init});
    if (!PRESETn) begin
      rises = 0; en_hi = 0; low_run = 0; en_prev = 0; first_rise = -1;
      cap.delete();
    end else begin
      if (bus.LCD_EN && !en_prev) begin
        rises++;
        en_hi = 0;
        last_gap = low_run;
        rise_cyc = cyc;
        if (first_rise < 0) first_rise = cyc;
        cap.push_back({bus.LCD_RS, bus.LCD_DATA});
        has   = exp_q.size() != 0;
        exp_b = has ? exp_q.pop_front() : 9'h000;
        check("byte_order", {22'd0, 1'b1, bus.LCD_RS, bus.LCD_DATA}, {22'd0, has, exp_b});
      end
      if (!bus.LCD_EN && en_prev) check("pulse_width", en_hi, TPU);
      if (bus.LCD_EN) begin
        en_hi++;
        low_run = 0;
      end else low_run++;
      en_prev = bus.LCD_EN;
    end
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!bus.req_ready && n < budget) begin
      step();
      n++;
    end
    check("ready_timeout", {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic wait_init(input int budget);
    int n = 0;
    while (!init_done && n < budget) begin
      step();
      n++;
    end
    check("init_done_cycle", cyc, 180);
  endtask

  task automatic send(input logic rs, input logic [7:0] d, output int lat);
    bus.req_valid = 1'b1;
    bus.req_rs    = rs;
    bus.req_data  = d;
    step();
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.req_ready && lat < 500) begin
      step();
      lat++;
    end
  endtask

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         lat;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, n, base;
    vecs[0] = '{1'b1, 8'h41, SHORT_LAT};
    vecs[1] = '{1'b0, 8'h01, LONG_LAT};
    vecs[2] = '{1'b0, 8'h80, SHORT_LAT};
    vecs[3] = '{1'b0, 8'h02, LONG_LAT};
    vecs[4] = '{1'b0, 8'h03, LONG_LAT};
    vecs[5] = '{1'b0, 8'h04, SHORT_LAT};
    vecs[6] = '{1'b1, 8'h00, SHORT_LAT};
    vecs[7] = '{1'b1, 8'h01, SHORT_LAT};
    bus.req_valid = 1'b0;
    bus.req_rs    = 1'b0;
    bus.req_data  = 8'h00;
    first_rise    = -1;

    // Reset release with no traffic: power-up gap then the init ROM.
    PRESETn = 1'b0;
    step();
    step();
    PRESETn = 1'b1;
    wait_init(400);
    check("first_en_cycle", first_rise, TP + TS);
    check("init_pulses", rises, 7);
    for (int i = 0; i < 7; i++) check("init_byte", {23'd0, cap[i]}, {23'd0, 1'b0, rom[i]});

    // Directed vectors: latency back to ready and the byte on the bus.
    foreach (vecs[i]) begin
      wait_ready(100);
      send(vecs[i].rs, vecs[i].data, lat);
      check("latency", lat, vecs[i].lat);
      check("emitted", {23'd0, cap[cap.size() - 1]}, {23'd0, vecs[i].rs, vecs[i].data});
    end

    // Back-to-back: valid held, second byte taken on the first ready cycle.
    wait_ready(100);
    base = rises;
    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b1;
    bus.req_data  = 8'h41;
    step();
    bus.req_data  = 8'h42;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      step();
      n++;
    end
    step();
    check("b2b_accept", {31'd0, bus.req_ready}, 32'd0);
    bus.req_valid = 1'b0;
    n = 0;
    while (rises < base + 2 && n < 100) begin
      step();
      n++;
    end
    // Low gap spans hold, execute, the single idle cycle and setup.
    check("b2b_gap", last_gap, TH + TE + 1 + TS);
    check("b2b_first", {23'd0, cap[base]}, {23'd0, 9'h141});
    check("b2b_second", {23'd0, cap[base + 1]}, {23'd0, 9'h142});
    wait_ready(100);

    // Valid asserted from reset: accepted only once init completes.
    PRESETn       = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b1;
    bus.req_data  = 8'h55;
    step();
    PRESETn = 1'b1;
    n = 0;
    while (rises < 8 && n < 400) begin
      step();
      n++;
    end
    bus.req_valid = 1'b0;
    check("early_byte_cycle", rise_cyc, 180 + 1 + TS);
    check("early_byte", {23'd0, cap[cap.size() - 1]}, {23'd0, 9'h155});
    wait_ready(100);

    // Reset while EN is high during a data write.
    bus.req_valid = 1'b1;
    bus.req_rs    = 1'b1;
    bus.req_data  = 8'h77;
    step();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.LCD_EN && n < 20) begin
      step();
      n++;
    end
    check("en_before_reset", {31'd0, bus.LCD_EN}, 32'd1);
    PRESETn = 1'b0;
    step();
    check("rst_en", {31'd0, bus.LCD_EN}, 32'd0);
    check("rst_data", {24'd0, bus.LCD_DATA}, 32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    PRESETn = 1'b1;
    wait_init(400);
    check("reinit_pulses", rises, 7);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      PRESETn       = ($urandom_range(0, 1499) != 0);
      bus.req_valid = ($urandom_range(0, 2) != 0);
      bus.req_rs    = 1'($urandom);
      bus.req_data  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
